// File: rtl/cfg_parameters.sv
// Shared configuration-bus register map and state types for the CNN coprocessor.
// Kernel loader registers live at addresses 4..6.
package cfg_parameters;

    localparam logic [4:0] CFG_KER_WR   = 5'd4;
    localparam logic [4:0] CFG_KER_RD   = 5'd5;
    localparam logic [4:0] CFG_KER_LOOP = 5'd6;

    typedef enum logic {
        W_IDLE,
        W_FILL
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RUN
    } rd_state_t;

endpackage

// File: rtl/kernel_row_mem.sv
// Simple dual-port synchronous row RAM; a same-address write and read return the old row.
module kernel_row_mem #(
    parameter int WIDTH  = 1024,
    parameter int AWIDTH = 10,
    parameter int DEPTH  = 1 << AWIDTH
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Non-blocking read and write in one block gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/kernel_loader.sv
// Kernel weight loader: packs the weight stream into full rows in a row memory,
// then replays an address range (optionally several passes) to the compute array.
module kernel_loader
    import cfg_parameters::*;
#(
    parameter int CFG_DWIDTH    = 32,
    parameter int CFG_AWIDTH    = 5,
    parameter int STR_KER_WIDTH = 64,
    parameter int GROUP_NB      = 4,
    parameter int KER_WIDTH     = 16,
    parameter int DEPTH_NB      = 16,
    parameter int MEM_AWIDTH    = 10,
    parameter int MEM_DEPTH     = 1 << MEM_AWIDTH
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [CFG_DWIDTH-1:0]                  cfg_data,
    input  logic [CFG_AWIDTH-1:0]                  cfg_addr,
    input  logic                                   cfg_valid,
    input  logic [STR_KER_WIDTH-1:0]               str_ker,
    input  logic                                   str_ker_val,
    output logic                                   str_ker_rdy,
    output logic [GROUP_NB*KER_WIDTH*DEPTH_NB-1:0] kernel,
    output logic                                   kernel_val,
    output logic                                   kernel_last,
    input  logic                                   kernel_rdy,
    output logic                                   wr_busy,
    output logic                                   rd_busy
);

    localparam int ROW_W  = GROUP_NB * KER_WIDTH * DEPTH_NB;
    localparam int BEATS  = ROW_W / STR_KER_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (ROW_W % STR_KER_WIDTH != 0) begin : g_bad_ratio
        $error("kernel_loader: row width must be a multiple of the stream width");
    end
    if (MEM_AWIDTH > 15 || CFG_DWIDTH < 15 + MEM_AWIDTH) begin : g_bad_awidth
        $error("kernel_loader: MEM_AWIDTH must be <= 15 and fit the read-range fields");
    end

    logic cfg_wr, cfg_rd, cfg_loop;
    assign cfg_wr   = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_KER_WR));
    assign cfg_rd   = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_KER_RD));
    assign cfg_loop = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_KER_LOOP));

    wr_state_t              wr_state_q, wr_state_d;
    logic [MEM_AWIDTH-1:0]  wr_end_q, wr_end_d;
    logic [MEM_AWIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [BEAT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [ROW_W-1:0]       acc_q, acc_d;
    logic                   beat_fire, row_done;
    logic [ROW_W-1:0]       row_word;

    rd_state_t              rd_state_q, rd_state_d;
    logic [MEM_AWIDTH-1:0]  rd_start_q, rd_start_d;
    logic [MEM_AWIDTH-1:0]  rd_end_q, rd_end_d;
    logic [MEM_AWIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic [15:0]            pass_cnt_q, pass_cnt_d;
    logic [15:0]            passes_q, passes_d;
    logic                   issue_done_q, issue_done_d;
    logic                   infl_q, infl_last_q, infl_final_q;
    logic                   v0_q, v0_d, v1_q, v1_d;
    logic [ROW_W-1:0]       data0_q, data0_d, data1_q, data1_d;
    logic                   last0_q, last0_d, last1_q, last1_d;
    logic                   final0_q, final0_d, final1_q, final1_d;
    logic                   pop, issue, at_end, last_pass;
    logic [1:0]             occ;
    logic [ROW_W-1:0]       mem_rd_data;

    // Rows fill from the top so beat 0 ends up in the lowest bits once the row is complete.
    assign beat_fire = str_ker_val && (wr_state_q == W_FILL);
    assign row_done  = beat_fire && (beat_cnt_q == BEAT_W'(BEATS - 1));
    assign row_word  = (acc_q >> STR_KER_WIDTH) | (ROW_W'(str_ker) << (ROW_W - STR_KER_WIDTH));

    always_comb begin
        wr_state_d = wr_state_q;
        wr_end_d   = wr_end_q;
        wr_addr_d  = wr_addr_q;
        beat_cnt_d = beat_cnt_q;
        acc_d      = acc_q;
        case (wr_state_q)
            W_IDLE: begin
                if (cfg_wr) begin
                    wr_end_d   = cfg_data[MEM_AWIDTH-1:0];
                    wr_addr_d  = '0;
                    beat_cnt_d = '0;
                    wr_state_d = W_FILL;
                end
            end
            W_FILL: begin
                if (beat_fire) begin
                    acc_d = row_word;
                    if (row_done) begin
                        beat_cnt_d = '0;
                        wr_addr_d  = wr_addr_q + 1'b1;
                        if (wr_addr_q == wr_end_q) begin
                            wr_state_d = W_IDLE;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // A new read may issue while buffered rows plus the one in flight stay within two slots.
    assign pop       = v0_q && kernel_rdy;
    assign occ       = 2'(v0_q) + 2'(v1_q) + 2'(infl_q) - 2'(pop);
    assign issue     = (rd_state_q == R_RUN) && !issue_done_q && (occ < 2'd2);
    assign at_end    = (rd_addr_q == rd_end_q);
    assign last_pass = ({1'b0, pass_cnt_q} + 17'd1) >= {1'b0, passes_q};

    always_comb begin
        rd_state_d   = rd_state_q;
        rd_start_d   = rd_start_q;
        rd_end_d     = rd_end_q;
        rd_addr_d    = rd_addr_q;
        pass_cnt_d   = pass_cnt_q;
        issue_done_d = issue_done_q;
        passes_d     = passes_q;
        if (cfg_loop) begin
            passes_d = (cfg_data[15:0] == 16'd0) ? 16'd1 : cfg_data[15:0];
        end
        case (rd_state_q)
            R_IDLE: begin
                if (cfg_rd) begin
                    rd_start_d   = cfg_data[0 +: MEM_AWIDTH];
                    rd_end_d     = cfg_data[15 +: MEM_AWIDTH];
                    rd_addr_d    = cfg_data[0 +: MEM_AWIDTH];
                    pass_cnt_d   = '0;
                    issue_done_d = 1'b0;
                    rd_state_d   = R_RUN;
                end
            end
            R_RUN: begin
                if (issue) begin
                    if (at_end) begin
                        rd_addr_d  = rd_start_q;
                        pass_cnt_d = pass_cnt_q + 16'd1;
                        if (last_pass) begin
                            issue_done_d = 1'b1;
                        end
                    end else begin
                        rd_addr_d = rd_addr_q + 1'b1;
                    end
                end
                if (pop && final0_q) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Two-entry output buffer: the head shifts out on pop, the returning read fills the first free slot.
    always_comb begin
        v0_d     = v0_q;
        v1_d     = v1_q;
        data0_d  = data0_q;
        data1_d  = data1_q;
        last0_d  = last0_q;
        last1_d  = last1_q;
        final0_d = final0_q;
        final1_d = final1_q;
        if (pop) begin
            v0_d     = v1_q;
            data0_d  = data1_q;
            last0_d  = last1_q;
            final0_d = final1_q;
            v1_d     = 1'b0;
        end
        if (infl_q) begin
            if (!v0_d) begin
                v0_d     = 1'b1;
                data0_d  = mem_rd_data;
                last0_d  = infl_last_q;
                final0_d = infl_final_q;
            end else begin
                v1_d     = 1'b1;
                data1_d  = mem_rd_data;
                last1_d  = infl_last_q;
                final1_d = infl_final_q;
            end
        end
        if (!v0_d) begin
            last0_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_state_q   <= W_IDLE;
            wr_end_q     <= '0;
            wr_addr_q    <= '0;
            beat_cnt_q   <= '0;
            acc_q        <= '0;
            rd_state_q   <= R_IDLE;
            rd_start_q   <= '0;
            rd_end_q     <= '0;
            rd_addr_q    <= '0;
            pass_cnt_q   <= '0;
            passes_q     <= 16'd1;
            issue_done_q <= 1'b0;
            infl_q       <= 1'b0;
            infl_last_q  <= 1'b0;
            infl_final_q <= 1'b0;
            v0_q         <= 1'b0;
            v1_q         <= 1'b0;
            data0_q      <= '0;
            data1_q      <= '0;
            last0_q      <= 1'b0;
            last1_q      <= 1'b0;
            final0_q     <= 1'b0;
            final1_q     <= 1'b0;
        end else begin
            wr_state_q   <= wr_state_d;
            wr_end_q     <= wr_end_d;
            wr_addr_q    <= wr_addr_d;
            beat_cnt_q   <= beat_cnt_d;
            acc_q        <= acc_d;
            rd_state_q   <= rd_state_d;
            rd_start_q   <= rd_start_d;
            rd_end_q     <= rd_end_d;
            rd_addr_q    <= rd_addr_d;
            pass_cnt_q   <= pass_cnt_d;
            passes_q     <= passes_d;
            issue_done_q <= issue_done_d;
            infl_q       <= issue;
            infl_last_q  <= at_end;
            infl_final_q <= at_end && last_pass;
            v0_q         <= v0_d;
            v1_q         <= v1_d;
            data0_q      <= data0_d;
            data1_q      <= data1_d;
            last0_q      <= last0_d;
            last1_q      <= last1_d;
            final0_q     <= final0_d;
            final1_q     <= final1_d;
        end
    end

    kernel_row_mem #(
        .WIDTH  (ROW_W),
        .AWIDTH (MEM_AWIDTH),
        .DEPTH  (MEM_DEPTH)
    ) u_row_mem (
        .clk     (clk),
        .wr_en   (row_done),
        .wr_addr (wr_addr_q),
        .wr_data (row_word),
        .rd_en   (issue),
        .rd_addr (rd_addr_q),
        .rd_data (mem_rd_data)
    );

    assign str_ker_rdy = (wr_state_q == W_FILL);
    assign wr_busy     = (wr_state_q == W_FILL);
    assign rd_busy     = (rd_state_q == R_RUN);
    assign kernel      = data0_q;
    assign kernel_val  = v0_q;
    assign kernel_last = last0_q;

endmodule
